// File: rtl/time_display.sv
// time_display: six-digit multiplexed seven-segment driver for the
// alarm-clock / stopwatch core. Once per display frame the time inputs are
// snapshotted and converted from binary to BCD by a repeated-subtraction
// engine. The result goes into a display buffer in a single cycle, and the
// buffer is scanned onto common-anode digits.
//
// Handshake / timing contract: there is no valid/ready pair on this block.
// The time inputs are sampled only in the LATCH cycle, and the display
// buffer changes only in the COMMIT cycle. Any change on Hours/Mins/Secs/
// MSecs/Control/AM_PM outside LATCH is invisible until the next frame.
// Alarm is sampled every cycle by the blink logic.
//
// fsm_state exposes the conversion FSM (0 IDLE, 1 LATCH, 2 CONV, 3 COMMIT)
// so that checkers can bind to it.

module time_display #(
  parameter int SCAN_DIV      = 10,    // cycles per digit slot, >= 7
  parameter int BLINK_DIV     = 2500,  // cycles per blink half-period, >= 2
  parameter bit LEADING_BLANK = 1'b1   // blank zero hours-tens in clock mode
) (
  input  logic       Clock_5K,
  input  logic       Reset,
  input  logic       Control,
  input  logic [3:0] Hours,
  input  logic [5:0] Mins,
  input  logic [5:0] Secs,
  input  logic [9:0] MSecs,
  input  logic       AM_PM,
  input  logic       Alarm,
  output logic [6:0] Seg,
  output logic       Dp,
  output logic [5:0] Digit_En,
  output logic       Alarm_Led,
  output logic [1:0] fsm_state
);

  localparam int PRE_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int BLK_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LATCH  = 2'd1,
    ST_CONV   = 2'd2,
    ST_COMMIT = 2'd3
  } state_t;

  // ---------------------------------------------------------------------
  // Scan timing
  // ---------------------------------------------------------------------
  logic [PRE_W-1:0] pre_cnt;
  logic [2:0]       slot;
  logic             pre_wrap;
  logic             frame_wrap;

  assign pre_wrap   = (pre_cnt == PRE_W'(SCAN_DIV - 1));
  assign frame_wrap = pre_wrap && (slot == 3'd5);

  // Prescaler counts within a slot; the slot index advances on its wrap.
  always_ff @(posedge Clock_5K or negedge Reset) begin
    if (!Reset) begin
      pre_cnt <= '0;
      slot    <= 3'd0;
    end else if (pre_wrap) begin
      pre_cnt <= '0;
      slot    <= (slot == 3'd5) ? 3'd0 : slot + 3'd1;
    end else begin
      pre_cnt <= pre_cnt + PRE_W'(1);
    end
  end

  // ---------------------------------------------------------------------
  // Conversion FSM
  // ---------------------------------------------------------------------
  state_t state;
  state_t next_state;
  logic   latch_en;
  logic   conv_en;
  logic   commit_en;
  logic   conv_done;
  logic   hund_step;

  // Conversion datapath registers
  logic       snap_mode;   // 1 = clock mode
  logic       snap_ampm;
  logic [5:0] snap_f1;     // second field (Mins or Secs)
  logic [9:0] snap_f2;     // third field (Secs or MSecs)
  logic [9:0] work;        // remainder of the field being converted
  logic [1:0] field;       // 0..2, field being converted
  logic [3:0] tens;        // subtract-by-10 count
  logic [3:0] hund;        // subtract-by-100 count (stopwatch MSecs only)
  logic       hund_phase;  // still subtracting 100 on the MSecs field
  logic [3:0] conv_d [0:5];

  // Display buffer
  logic [3:0] disp_d [0:5];
  logic       disp_mode;
  logic       disp_ampm;

  // The MSecs field in stopwatch mode first peels off hundreds.
  assign hund_step = conv_en && (field == 2'd2) && !snap_mode && hund_phase;

  // Last finalize cycle: third field, no hundreds left, remainder below 10.
  assign conv_done = conv_en && (field == 2'd2) && !hund_step
                     && (work < 10'd10);

  // State register.
  always_ff @(posedge Clock_5K or negedge Reset) begin
    if (!Reset) state <= ST_IDLE;
    else        state <= next_state;
  end

  // Next-state logic: one conversion per frame, started at the 5->0 wrap.
  always_comb begin
    next_state = state;
    case (state)
      ST_IDLE:   if (frame_wrap) next_state = ST_LATCH;
      ST_LATCH:  next_state = ST_CONV;
      ST_CONV:   if (conv_done) next_state = ST_COMMIT;
      ST_COMMIT: next_state = ST_IDLE;
      default:   next_state = ST_IDLE;
    endcase
  end

  // FSM output decode.
  always_comb begin
    latch_en  = 1'b0;
    conv_en   = 1'b0;
    commit_en = 1'b0;
    case (state)
      ST_LATCH:  latch_en  = 1'b1;
      ST_CONV:   conv_en   = 1'b1;
      ST_COMMIT: commit_en = 1'b1;
      default:   ;
    endcase
  end

  assign fsm_state = state;

  // Snapshot and repeated-subtraction BCD conversion. The first field is
  // loaded straight into the work register at LATCH; the other two are
  // held in snapshot registers until their turn.
  always_ff @(posedge Clock_5K or negedge Reset) begin
    if (!Reset) begin
      snap_mode  <= 1'b1;
      snap_ampm  <= 1'b0;
      snap_f1    <= '0;
      snap_f2    <= '0;
      work       <= '0;
      field      <= 2'd0;
      tens       <= 4'd0;
      hund       <= 4'd0;
      hund_phase <= 1'b0;
      for (int i = 0; i < 6; i++) conv_d[i] <= 4'd0;
    end else if (latch_en) begin
      snap_mode  <= Control;
      snap_ampm  <= AM_PM;
      snap_f1    <= Control ? Mins : Secs;
      snap_f2    <= Control ? {4'd0, Secs} : MSecs;
      work       <= Control ? {6'd0, Hours} : {4'd0, Mins};
      field      <= 2'd0;
      tens       <= 4'd0;
      hund       <= 4'd0;
      hund_phase <= 1'b1;
    end else if (conv_en) begin
      if (hund_step) begin
        if (work >= 10'd100) begin
          work <= work - 10'd100;
          hund <= hund + 4'd1;
        end else begin
          hund_phase <= 1'b0;
        end
      end else if (work >= 10'd10) begin
        work <= work - 10'd10;
        tens <= tens + 4'd1;
      end else begin
        // Finalize the current field and load the next one.
        tens  <= 4'd0;
        field <= field + 2'd1;
        case (field)
          2'd0: begin
            conv_d[0] <= tens;
            conv_d[1] <= work[3:0];
            work      <= {4'd0, snap_f1};
          end
          2'd1: begin
            conv_d[2] <= tens;
            conv_d[3] <= work[3:0];
            work      <= snap_f2;
          end
          default: begin
            if (snap_mode) begin
              conv_d[4] <= tens;
              conv_d[5] <= work[3:0];
            end else begin
              // Hundredths of a second: hundreds and tens of ms,
              // the ms units remainder is dropped.
              conv_d[4] <= hund;
              conv_d[5] <= tens;
            end
          end
        endcase
      end
    end
  end

  // Display buffer: all six digits plus mode and AM/PM change together.
  always_ff @(posedge Clock_5K or negedge Reset) begin
    if (!Reset) begin
      for (int i = 0; i < 6; i++) disp_d[i] <= 4'd0;
      disp_mode <= 1'b1;
      disp_ampm <= 1'b0;
    end else if (commit_en) begin
      for (int i = 0; i < 6; i++) disp_d[i] <= conv_d[i];
      disp_mode <= snap_mode;
      disp_ampm <= snap_ampm;
    end
  end

  // ---------------------------------------------------------------------
  // Alarm blink
  // ---------------------------------------------------------------------
  logic [BLK_W-1:0] blink_cnt;
  logic             blink_on;

  // Phase toggles every BLINK_DIV cycles while Alarm is high; cleared to
  // the on phase whenever Alarm is low so each alarm starts lit.
  always_ff @(posedge Clock_5K or negedge Reset) begin
    if (!Reset) begin
      blink_cnt <= '0;
      blink_on  <= 1'b1;
    end else if (!Alarm) begin
      blink_cnt <= '0;
      blink_on  <= 1'b1;
    end else if (blink_cnt == BLK_W'(BLINK_DIV - 1)) begin
      blink_cnt <= '0;
      blink_on  <= ~blink_on;
    end else begin
      blink_cnt <= blink_cnt + BLK_W'(1);
    end
  end

  // ---------------------------------------------------------------------
  // Segment decode and output stage
  // ---------------------------------------------------------------------
  function automatic logic [6:0] seg_decode(input logic [3:0] d);
    logic [6:0] p;
    case (d)
      4'd0:    p = 7'h40;
      4'd1:    p = 7'h79;
      4'd2:    p = 7'h24;
      4'd3:    p = 7'h30;
      4'd4:    p = 7'h19;
      4'd5:    p = 7'h12;
      4'd6:    p = 7'h02;
      4'd7:    p = 7'h78;
      4'd8:    p = 7'h00;
      4'd9:    p = 7'h10;
      default: p = 7'h7F;
    endcase
    return p;
  endfunction

  logic [3:0] cur_digit;
  logic       ghost;
  logic       lead_blank;
  logic       blink_off;
  logic [6:0] seg_nxt;
  logic [5:0] en_nxt;
  logic       dp_nxt;
  logic       led_nxt;

  // Next output values from the current slot, prescaler, buffer and blink.
  always_comb begin
    cur_digit  = disp_d[slot];
    ghost      = (pre_cnt == '0);
    lead_blank = LEADING_BLANK && disp_mode && (slot == 3'd0)
                 && (disp_d[0] == 4'd0);
    blink_off  = Alarm && !blink_on;
    seg_nxt    = (ghost || lead_blank) ? 7'h7F : seg_decode(cur_digit);
    en_nxt     = (ghost || blink_off) ? 6'h3F : ~(6'b100000 >> slot);
    dp_nxt     = 1'b1;
    if (!ghost) begin
      if ((slot == 3'd1) || (slot == 3'd3)) dp_nxt = 1'b0;
      if ((slot == 3'd5) && disp_mode && disp_ampm) dp_nxt = 1'b0;
    end
    led_nxt    = Alarm && blink_on;
  end

  // Registered pin drivers.
  always_ff @(posedge Clock_5K or negedge Reset) begin
    if (!Reset) begin
      Seg       <= 7'h7F;
      Dp        <= 1'b1;
      Digit_En  <= 6'h3F;
      Alarm_Led <= 1'b0;
    end else begin
      Seg       <= seg_nxt;
      Dp        <= dp_nxt;
      Digit_En  <= en_nxt;
      Alarm_Led <= led_nxt;
    end
  end

endmodule
